wb_exc_commit: RTL and testbench
================================

Name: wb_exc_commit

Overview:
- WB-stage commit block; the producing end of the WB->CSR interface.
- Registers the instruction from MEM and arbitrates its exception flags into one ecode/esubcode.
- Drives the CSR write port and the `WB2CSR_LEN (49-bit) CSR bus {ertn_flush, wb_ex, ecode[5:0], esubcode[8:0], pc[31:0]}.
- Generates the pipeline flush and redirect target, and kills wrong-path instructions with a 1-bit epoch.

Parameters:
- PC_W, 32, PC / data width.
- RF_AW, 5, register-file address width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
mem_to_wb_valid  in  1  MEM holds an instruction
mem_epoch  in  1  epoch tag carried by the instruction
mem_pc  in  PC_W  instruction PC
mem_ex_vec  in  6  {int, adef, ine, sys, brk, ale} raw exception flags
mem_is_ertn  in  1  instruction is ERTN
mem_csr_we  in  1  CSR write request
mem_csr_num  in  14  CSR address
mem_csr_wmask  in  32  CSR write mask
mem_csr_wvalue  in  32  CSR write value
mem_rf_we  in  1  GPR write request
mem_rf_waddr  in  RF_AW  GPR address
mem_rf_wdata  in  PC_W  GPR data
wb_allowin  out  1  WB can accept; constant 1
csr_we  out  1  CSR write enable
csr_num  out  14  CSR address
csr_wmask  out  32  CSR write mask
csr_wvalue  out  32  CSR write value
csr_in_bus  out  49  {ertn_flush, wb_ex, ecode, esubcode, pc}
ex_entry  in  32  exception vector from CSR file
ertn_entry  in  32  return address from CSR file
wb_flush  out  1  flush whole pipeline, one-cycle pulse
flush_target  out  PC_W  redirect PC when wb_flush=1
cur_epoch  out  1  epoch front-end tags new fetches with
rf_we  out  1  GPR write enable
rf_waddr  out  RF_AW  GPR address
rf_wdata  out  PC_W  GPR data

Behaviour:
- Reset (async, reset=1): wb_valid=0, cur_epoch=0, all payload regs 0.
  - All outputs are 0 during reset, except wb_allowin=1.
- Capture at posedge:
  - Condition: mem_to_wb_valid && !kill, where kill = wb_flush || (mem_epoch != cur_epoch).
  - When the condition holds, wb_valid<=1 and the payload registers load.
  - Otherwise wb_valid<=0.
  - Killed instructions never reach outputs.
- Latency: outputs reflect the captured instruction in the cycle after capture, for exactly one cycle (WB ready_go=1).
- Exception priority, highest first (ecode, esubcode):
  - int: 0x00, 0
  - adef: 0x08, 0
  - ine: 0x0D, 0
  - sys: 0x0B, 0
  - brk: 0x0C, 0
  - ale: 0x09, 0
- Exception and ERTN decode:
  - wb_ex = wb_valid & |ex_vec.
  - ertn_flush = wb_valid & is_ertn & ~wb_ex; an exception wins over ERTN.
  - With no exception, ecode=0 and esubcode=0.
  - csr_in_bus pc field = wb_pc when wb_valid, else 0.
- Side-effect suppression:
  - csr_we = wb_valid & csr_we_r & ~wb_ex & ~ertn_flush.
  - rf_we = wb_valid & rf_we_r & ~wb_ex.
  - csr_num, csr_wmask, csr_wvalue, rf_waddr and rf_wdata pass through from the payload registers.
- Flush:
  - wb_flush = wb_ex | ertn_flush.
  - flush_target = wb_ex ? ex_entry : ertn_entry.
  - Flush outputs are combinational in the commit cycle.
- Epoch:
  - On the edge ending a flush cycle, cur_epoch toggles.
  - The MEM instruction presented in that cycle is discarded regardless of its tag.
  - Afterwards, every instruction tagged with the old epoch is discarded until one arrives tagged with the new epoch.
- Back-to-back flushes: each commit cycle toggles the epoch again. No flush can occur on a killed slot.
- Reset mid-flush: the flush is abandoned and cur_epoch returns to 0.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- When defined, adds outputs:
  - debug_wb_pc (PC_W) = wb_pc
  - debug_wb_rf_we (4) = {4{rf_we}}
  - debug_wb_rf_wnum (RF_AW) = rf_waddr
  - debug_wb_rf_wdata (PC_W) = rf_wdata
- The debug outputs are 0 when wb_valid=0.
- When undefined, the ports and their logic are absent; functional behaviour is identical.

Test Plan:
- Normal commit:
  - Stimulus: valid, epoch 0, pc=0x1c000000, rf_we=1, waddr=5, wdata=0x1234.
  - Required next cycle: rf_we=1, waddr=5, wdata=0x1234; csr_in_bus={0,0,0,0,0x1c000000}; wb_flush=0.
- SYSCALL:
  - Stimulus: ex_vec sys=1, pc=0x1c000010, ex_entry=0x1c008000, rf_we=1.
  - Required: wb_ex=1, ecode=0x0B, wb_flush=1, flush_target=0x1c008000, rf_we=0.
  - Required: cur_epoch 0->1, and the instruction presented that cycle is dropped.
- Priority:
  - Stimulus: ex_vec with int, ine and ale all set.
  - Required: ecode=0x00.
  - Stimulus: ex_vec with adef and ale set.
  - Required: ecode=0x08.
- ERTN:
  - Stimulus: is_ertn=1, csr_we=1, ertn_entry=0x1c000420.
  - Required: ertn_flush=1, csr_we=0, flush_target=0x1c000420.
  - Stimulus: is_ertn=1 with brk also set.
  - Required: wb_ex=1, ertn_flush=0, ecode=0x0C.
- Stale epoch:
  - Stimulus: after a flush (cur_epoch=1), three valid instructions with epoch 0, then one with epoch 1.
  - Required: only the last commits; no rf_we and no csr_we for the first three.
- Async reset:
  - Stimulus: assert reset between clock edges during a commit cycle.
  - Required: immediately wb_flush=0, rf_we=0, csr_in_bus=0, cur_epoch=0.

Source files
------------

// File: rtl/wb_exc_commit_if.sv
// wb_exc_commit_if: bundles every signal that crosses the boundary of the WB commit block.
//
// Groups:
//   MEM -> WB   : mem_to_wb_valid, mem_epoch, mem_pc, mem_ex_vec, mem_is_ertn,
//                 mem_csr_we/num/wmask/wvalue, mem_rf_we/waddr/wdata
//   CSR -> WB   : ex_entry, ertn_entry
//   WB  -> CSR  : csr_we/num/wmask/wvalue, csr_in_bus {ertn_flush, wb_ex, ecode, esubcode, pc}
//   WB  -> pipe : wb_allowin, wb_flush, flush_target, cur_epoch
//   WB  -> GPR  : rf_we, rf_waddr, rf_wdata
//   Optional    : debug_wb_* trace outputs, present only when WB_DEBUG_TRACE_EN is defined.
//
// Modports:
//   master : the commit block (drives the CSR, GPR and flush side)
//   slave  : the surroundings (MEM stage, CSR file, register file, front-end)

`ifndef WB2CSR_LEN
`define WB2CSR_LEN 49
`endif

interface wb_exc_commit_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned RF_AW = 5
);
    // MEM -> WB
    logic                   mem_to_wb_valid;
    logic                   mem_epoch;
    logic [PC_W-1:0]        mem_pc;
    logic [5:0]             mem_ex_vec;
    logic                   mem_is_ertn;
    logic                   mem_csr_we;
    logic [13:0]            mem_csr_num;
    logic [31:0]            mem_csr_wmask;
    logic [31:0]            mem_csr_wvalue;
    logic                   mem_rf_we;
    logic [RF_AW-1:0]       mem_rf_waddr;
    logic [PC_W-1:0]        mem_rf_wdata;

    // CSR -> WB
    logic [31:0]            ex_entry;
    logic [31:0]            ertn_entry;

    // WB -> CSR / pipeline / GPR
    logic                   wb_allowin;
    logic                   csr_we;
    logic [13:0]            csr_num;
    logic [31:0]            csr_wmask;
    logic [31:0]            csr_wvalue;
    logic [`WB2CSR_LEN-1:0] csr_in_bus;
    logic                   wb_flush;
    logic [PC_W-1:0]        flush_target;
    logic                   cur_epoch;
    logic                   rf_we;
    logic [RF_AW-1:0]       rf_waddr;
    logic [PC_W-1:0]        rf_wdata;

`ifdef WB_DEBUG_TRACE_EN
    logic [PC_W-1:0]        debug_wb_pc;
    logic [3:0]             debug_wb_rf_we;
    logic [RF_AW-1:0]       debug_wb_rf_wnum;
    logic [PC_W-1:0]        debug_wb_rf_wdata;
`endif

    modport master (
        input  mem_to_wb_valid, mem_epoch, mem_pc, mem_ex_vec, mem_is_ertn,
        input  mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wvalue,
        input  mem_rf_we, mem_rf_waddr, mem_rf_wdata,
        input  ex_entry, ertn_entry,
        output wb_allowin, csr_we, csr_num, csr_wmask, csr_wvalue, csr_in_bus,
        output wb_flush, flush_target, cur_epoch,
        output rf_we, rf_waddr, rf_wdata
`ifdef WB_DEBUG_TRACE_EN
        ,
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
    );

    modport slave (
        output mem_to_wb_valid, mem_epoch, mem_pc, mem_ex_vec, mem_is_ertn,
        output mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wvalue,
        output mem_rf_we, mem_rf_waddr, mem_rf_wdata,
        output ex_entry, ertn_entry,
        input  wb_allowin, csr_we, csr_num, csr_wmask, csr_wvalue, csr_in_bus,
        input  wb_flush, flush_target, cur_epoch,
        input  rf_we, rf_waddr, rf_wdata
`ifdef WB_DEBUG_TRACE_EN
        ,
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
    );

endinterface

// File: rtl/wb_exc_commit.sv
// wb_exc_commit: write-back stage commit block.
//
// Registers the instruction handed over by MEM, folds its raw exception flags into a single
// ecode/esubcode, drives the CSR write port and the WB->CSR bus, writes the GPR file, and
// raises a one-cycle pipeline flush (exception or ERTN) together with the redirect target.
// Wrong-path instructions are discarded with a 1-bit epoch that toggles after every flush.
//
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : wb_exc_commit_if.master (MEM inputs, CSR entries, CSR/GPR/flush outputs)
//
// csr_in_bus layout: {ertn_flush, wb_ex, ecode[5:0], esubcode[8:0], pc[31:0]}
// mem_ex_vec layout: {int, adef, ine, sys, brk, ale}, int has the highest priority.
//
// Optional feature macro: WB_DEBUG_TRACE_EN adds the debug_wb_* trace outputs.

module wb_exc_commit #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned RF_AW = 5
) (
    input logic             clk,
    input logic             reset,
    wb_exc_commit_if.master bus
);

    localparam logic [5:0] EcodeInt  = 6'h00;
    localparam logic [5:0] EcodeAdef = 6'h08;
    localparam logic [5:0] EcodeIne  = 6'h0D;
    localparam logic [5:0] EcodeSys  = 6'h0B;
    localparam logic [5:0] EcodeBrk  = 6'h0C;
    localparam logic [5:0] EcodeAle  = 6'h09;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             wb_valid_q,   wb_valid_d;
    logic             cur_epoch_q,  cur_epoch_d;
    logic [PC_W-1:0]  pc_q,         pc_d;
    logic [5:0]       ex_vec_q,     ex_vec_d;
    logic             is_ertn_q,    is_ertn_d;
    logic             csr_we_q,     csr_we_d;
    logic [13:0]      csr_num_q,    csr_num_d;
    logic [31:0]      csr_wmask_q,  csr_wmask_d;
    logic [31:0]      csr_wvalue_q, csr_wvalue_d;
    logic             rf_we_q,      rf_we_d;
    logic [RF_AW-1:0] rf_waddr_q,   rf_waddr_d;
    logic [PC_W-1:0]  rf_wdata_q,   rf_wdata_d;

    // ------------------------------------------------------------------
    // Commit-cycle decode
    // ------------------------------------------------------------------
    logic            wb_ex;
    logic            ertn_flush;
    logic            flush;
    logic [5:0]      ecode;
    logic [8:0]      esubcode;
    logic [PC_W-1:0] bus_pc;

    always_comb begin
        wb_ex      = wb_valid_q & (|ex_vec_q);
        // An exception on an ERTN wins; the ERTN itself never retires.
        ertn_flush = wb_valid_q & is_ertn_q & ~wb_ex;
        flush      = wb_ex | ertn_flush;
        esubcode   = 9'd0;
        ecode      = 6'd0;
        if (wb_ex) begin
            if      (ex_vec_q[5]) ecode = EcodeInt;
            else if (ex_vec_q[4]) ecode = EcodeAdef;
            else if (ex_vec_q[3]) ecode = EcodeIne;
            else if (ex_vec_q[2]) ecode = EcodeSys;
            else if (ex_vec_q[1]) ecode = EcodeBrk;
            else                  ecode = EcodeAle;
        end
        bus_pc = wb_valid_q ? pc_q : '0;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    logic kill;
    logic capture;

    always_comb begin
        // The slot behind a flushing instruction is always wrong-path, whatever its tag.
        kill    = flush | (bus.mem_epoch != cur_epoch_q);
        capture = bus.mem_to_wb_valid & ~kill;

        wb_valid_d   = capture;
        cur_epoch_d  = cur_epoch_q ^ flush;

        pc_d         = pc_q;
        ex_vec_d     = ex_vec_q;
        is_ertn_d    = is_ertn_q;
        csr_we_d     = csr_we_q;
        csr_num_d    = csr_num_q;
        csr_wmask_d  = csr_wmask_q;
        csr_wvalue_d = csr_wvalue_q;
        rf_we_d      = rf_we_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        if (capture) begin
            pc_d         = bus.mem_pc;
            ex_vec_d     = bus.mem_ex_vec;
            is_ertn_d    = bus.mem_is_ertn;
            csr_we_d     = bus.mem_csr_we;
            csr_num_d    = bus.mem_csr_num;
            csr_wmask_d  = bus.mem_csr_wmask;
            csr_wvalue_d = bus.mem_csr_wvalue;
            rf_we_d      = bus.mem_rf_we;
            rf_waddr_d   = bus.mem_rf_waddr;
            rf_wdata_d   = bus.mem_rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q   <= 1'b0;
            cur_epoch_q  <= 1'b0;
            pc_q         <= '0;
            ex_vec_q     <= '0;
            is_ertn_q    <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            cur_epoch_q  <= cur_epoch_d;
            pc_q         <= pc_d;
            ex_vec_q     <= ex_vec_d;
            is_ertn_q    <= is_ertn_d;
            csr_we_q     <= csr_we_d;
            csr_num_q    <= csr_num_d;
            csr_wmask_q  <= csr_wmask_d;
            csr_wvalue_q <= csr_wvalue_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wb_allowin = 1'b1;

    // Faulting and ERTN instructions must not update CSRs; faulting ones must not write GPRs.
    assign bus.csr_we     = wb_valid_q & csr_we_q & ~wb_ex & ~ertn_flush;
    assign bus.csr_num    = csr_num_q;
    assign bus.csr_wmask  = csr_wmask_q;
    assign bus.csr_wvalue = csr_wvalue_q;
    assign bus.csr_in_bus = {ertn_flush, wb_ex, ecode, esubcode, bus_pc};

    assign bus.rf_we      = wb_valid_q & rf_we_q & ~wb_ex;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;

    assign bus.wb_flush   = flush;
    // Held at 0 outside a flush so nothing leaks from the CSR file while reset is applied.
    assign bus.flush_target = wb_ex      ? bus.ex_entry   :
                              ertn_flush ? bus.ertn_entry : '0;
    assign bus.cur_epoch  = cur_epoch_q;

`ifdef WB_DEBUG_TRACE_EN
    assign bus.debug_wb_pc       = wb_valid_q ? pc_q : '0;
    assign bus.debug_wb_rf_we    = {4{bus.rf_we}};
    assign bus.debug_wb_rf_wnum  = wb_valid_q ? rf_waddr_q : '0;
    assign bus.debug_wb_rf_wdata = wb_valid_q ? rf_wdata_q : '0;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
`timescale 1ns/1ps

module tb_wb_exc_commit;

    localparam int PC_W  = 32;
    localparam int RF_AW = 5;

    // Exception sources from highest to lowest priority: int, adef, ine, sys, brk, ale.
    localparam logic [5:0] ECODE_TAB [6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_exc_commit_if #(.PC_W(PC_W), .RF_AW(RF_AW)) bus ();

    wb_exc_commit #(.PC_W(PC_W), .RF_AW(RF_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: the instruction sitting in WB plus the live epoch.
    // ------------------------------------------------------------------
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  ex;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } instr_t;

    instr_t m_slot;
    logic   m_epoch;

    logic        e_ex, e_ertn, e_flush, e_rf_we, e_csr_we;
    logic [5:0]  e_ecode;
    logic [31:0] e_target;
    logic [48:0] e_bus;

    function automatic logic [5:0] ref_ecode(input logic [5:0] ex);
        for (int i = 0; i < 6; i++) begin
            if (ex[5-i]) return ECODE_TAB[i];
        end
        return 6'h00;
    endfunction

    task automatic compute_expected();
        e_ex     = m_slot.valid && (m_slot.ex != 6'd0);
        e_ertn   = m_slot.valid && m_slot.ertn && !e_ex;
        e_flush  = e_ex || e_ertn;
        e_ecode  = e_ex ? ref_ecode(m_slot.ex) : 6'h00;
        e_target = e_ex ? bus.ex_entry : bus.ertn_entry;
        e_rf_we  = m_slot.valid && m_slot.rf_we && !e_ex;
        e_csr_we = m_slot.valid && m_slot.csr_we && !e_flush;
        e_bus    = {e_ertn, e_ex, e_ecode, 9'd0, (m_slot.valid ? m_slot.pc : 32'd0)};
    endtask

    task automatic model_reset();
        m_slot  = '{default: '0};
        m_epoch = 1'b0;
        compute_expected();
    endtask

    // Advance DUT and model by one edge; outputs are sampled 1ns after the edge.
    task automatic tick();
        logic flush_now;
        instr_t nxt;
        compute_expected();
        flush_now = e_flush;
        @(posedge clk);
        nxt.valid  = bus.mem_to_wb_valid && !flush_now && (bus.mem_epoch == m_epoch);
        nxt.pc     = bus.mem_pc;
        nxt.ex     = bus.mem_ex_vec;
        nxt.ertn   = bus.mem_is_ertn;
        nxt.csr_we = bus.mem_csr_we;
        nxt.csr_num = bus.mem_csr_num;
        nxt.wmask  = bus.mem_csr_wmask;
        nxt.wvalue = bus.mem_csr_wvalue;
        nxt.rf_we  = bus.mem_rf_we;
        nxt.waddr  = bus.mem_rf_waddr;
        nxt.wdata  = bus.mem_rf_wdata;
        if (nxt.valid) m_slot = nxt;
        else           m_slot.valid = 1'b0;
        if (flush_now) m_epoch = ~m_epoch;
        #1;
        compute_expected();
    endtask

    task automatic idle();
        bus.mem_to_wb_valid = 1'b0;
        bus.mem_epoch       = 1'b0;
        bus.mem_pc          = '0;
        bus.mem_ex_vec      = '0;
        bus.mem_is_ertn     = 1'b0;
        bus.mem_csr_we      = 1'b0;
        bus.mem_csr_num     = '0;
        bus.mem_csr_wmask   = '0;
        bus.mem_csr_wvalue  = '0;
        bus.mem_rf_we       = 1'b0;
        bus.mem_rf_waddr    = '0;
        bus.mem_rf_wdata    = '0;
    endtask

    task automatic present(input logic ep, input logic [31:0] pc, input logic [5:0] ex,
                           input logic ertn, input logic cwe, input logic rfwe,
                           input logic [4:0] wa, input logic [31:0] wd);
        bus.mem_to_wb_valid = 1'b1;
        bus.mem_epoch       = ep;
        bus.mem_pc          = pc;
        bus.mem_ex_vec      = ex;
        bus.mem_is_ertn     = ertn;
        bus.mem_csr_we      = cwe;
        bus.mem_csr_num     = 14'($urandom);
        bus.mem_csr_wmask   = $urandom;
        bus.mem_csr_wvalue  = $urandom;
        bus.mem_rf_we       = rfwe;
        bus.mem_rf_waddr    = wa;
        bus.mem_rf_wdata    = wd;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.ex_entry   = 32'h1c00_8000;
        bus.ertn_entry = 32'h1c00_0420;
        model_reset();
        #12;
        checks++; if (bus.wb_allowin !== 1'b1) begin errors++;
            $display("FAIL reset_allowin: got %0h want 1", bus.wb_allowin); end
        checks++; if (bus.wb_flush !== 1'b0) begin errors++;
            $display("FAIL reset_flush: got %0h want 0", bus.wb_flush); end
        checks++; if (bus.flush_target !== 32'd0) begin errors++;
            $display("FAIL reset_target: got %0h want 0", bus.flush_target); end
        checks++; if (bus.csr_in_bus !== 49'd0) begin errors++;
            $display("FAIL reset_bus: got %0h want 0", bus.csr_in_bus); end
        checks++; if ({bus.rf_we, bus.csr_we, bus.cur_epoch} !== 3'b000) begin errors++;
            $display("FAIL reset_we_epoch: got %b want 000", {bus.rf_we, bus.csr_we, bus.cur_epoch}); end
        checks++; if ({bus.rf_waddr, bus.rf_wdata, bus.csr_num} !== '0) begin errors++;
            $display("FAIL reset_payload: got %0h want 0", {bus.rf_waddr, bus.rf_wdata, bus.csr_num}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_normal_commit();
        present(m_epoch, 32'h1c00_0000, 6'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
        tick();
        idle();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234)
            begin errors++; $display("FAIL normal_rf: got we=%0h a=%0h d=%0h want 1/5/1234",
                bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        checks++; if (bus.csr_in_bus !== {17'd0, 32'h1c00_0000}) begin errors++;
            $display("FAIL normal_bus: got %0h want 1c000000", bus.csr_in_bus); end
        checks++; if (bus.wb_flush !== 1'b0) begin errors++;
            $display("FAIL normal_flush: got %0h want 0", bus.wb_flush); end
        tick();
        checks++; if (bus.rf_we !== 1'b0) begin errors++;
            $display("FAIL normal_one_cycle: got rf_we=%0h want 0", bus.rf_we); end
    endtask

    task automatic test_syscall();
        bus.ex_entry = 32'h1c00_8000;
        present(m_epoch, 32'h1c00_0010, 6'b000100, 1'b0, 1'b0, 1'b1, 5'd7, 32'hdead);
        tick();
        // Present a new-epoch instruction in the flush cycle: it must still be dropped.
        present(~m_epoch, 32'h1c00_0014, 6'd0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hbeef);
        checks++; if (bus.csr_in_bus[47] !== 1'b1 || bus.csr_in_bus[46:41] !== 6'h0B) begin
            errors++; $display("FAIL sys_ecode: got ex=%0h ecode=%0h want 1/0b",
                bus.csr_in_bus[47], bus.csr_in_bus[46:41]); end
        checks++; if (bus.wb_flush !== 1'b1 || bus.flush_target !== 32'h1c00_8000) begin
            errors++; $display("FAIL sys_flush: got %0h/%0h want 1/1c008000",
                bus.wb_flush, bus.flush_target); end
        checks++; if (bus.rf_we !== 1'b0 || bus.cur_epoch !== 1'b0) begin errors++;
            $display("FAIL sys_rfwe_epoch: got %0h/%0h want 0/0", bus.rf_we, bus.cur_epoch); end
        tick();
        idle();
        checks++; if (bus.cur_epoch !== 1'b1) begin errors++;
            $display("FAIL sys_epoch_toggle: got %0h want 1", bus.cur_epoch); end
        checks++; if ({bus.rf_we, bus.csr_we, bus.wb_flush} !== 3'b000 || bus.csr_in_bus !== '0)
            begin errors++; $display("FAIL sys_dropped: got %b bus=%0h want 000 bus=0",
                {bus.rf_we, bus.csr_we, bus.wb_flush}, bus.csr_in_bus); end
    endtask

    task automatic test_priority();
        logic [5:0] vecs [2];
        logic [5:0] want [2];
        vecs[0] = 6'b101001; want[0] = 6'h00;
        vecs[1] = 6'b010001; want[1] = 6'h08;
        for (int i = 0; i < 2; i++) begin
            present(m_epoch, 32'h1c00_0100 + 32'(i * 4), vecs[i], 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            tick();
            idle();
            checks++; if (bus.csr_in_bus[46:41] !== want[i] || bus.csr_in_bus[47] !== 1'b1) begin
                errors++; $display("FAIL prio_%0d: got ecode=%0h want %0h",
                    i, bus.csr_in_bus[46:41], want[i]); end
            tick();
        end
    endtask

    task automatic test_ertn();
        bus.ertn_entry = 32'h1c00_0420;
        present(m_epoch, 32'h1c00_0200, 6'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        checks++; if (bus.csr_in_bus[48] !== 1'b1 || bus.csr_we !== 1'b0) begin errors++;
            $display("FAIL ertn_flag: got ertn=%0h csr_we=%0h want 1/0",
                bus.csr_in_bus[48], bus.csr_we); end
        checks++; if (bus.wb_flush !== 1'b1 || bus.flush_target !== 32'h1c00_0420) begin
            errors++; $display("FAIL ertn_target: got %0h/%0h want 1/1c000420",
                bus.wb_flush, bus.flush_target); end
        tick();
        present(m_epoch, 32'h1c00_0300, 6'b000010, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        checks++; if (bus.csr_in_bus[48:41] !== {1'b0, 1'b1, 6'h0C}) begin errors++;
            $display("FAIL ertn_brk: got {ertn,ex,ecode}=%0h want 4c", bus.csr_in_bus[48:41]); end
        checks++; if (bus.flush_target !== bus.ex_entry) begin errors++;
            $display("FAIL ertn_brk_target: got %0h want %0h", bus.flush_target, bus.ex_entry); end
        tick();
    endtask

    task automatic test_stale_epoch();
        logic old_ep;
        pulse_reset();
        old_ep = m_epoch;
        present(m_epoch, 32'h1c00_0400, 6'b000001, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        tick();
        checks++; if (bus.cur_epoch !== 1'b1) begin errors++;
            $display("FAIL stale_epoch_val: got %0h want 1", bus.cur_epoch); end
        for (int i = 0; i < 3; i++) begin
            present(old_ep, 32'h1c00_0500 + 32'(i * 4), 6'd0, 1'b0, 1'b1, 1'b1,
                    5'(i + 1), 32'(i));
            tick();
            checks++; if (bus.rf_we !== 1'b0 || bus.csr_we !== 1'b0) begin errors++;
                $display("FAIL stale_drop_%0d: got rf_we=%0h csr_we=%0h want 0/0",
                    i, bus.rf_we, bus.csr_we); end
        end
        present(~old_ep, 32'h1c00_0600, 6'd0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h55aa);
        tick();
        idle();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.csr_we !== 1'b1) begin
            errors++; $display("FAIL stale_new_commit: got rf_we=%0h a=%0h csr_we=%0h want 1/c/1",
                bus.rf_we, bus.rf_waddr, bus.csr_we); end
        tick();
    endtask

    task automatic test_async_reset();
        // Reach epoch 1 first so the return to 0 is visible.
        if (m_epoch == 1'b0) begin
            present(m_epoch, 32'h1c00_0700, 6'b000010, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            tick();
            idle();
            tick();
        end
        present(m_epoch, 32'h1c00_0800, 6'b000100, 1'b0, 1'b1, 1'b1, 5'd3, 32'h77);
        tick();
        idle();
        checks++; if (bus.wb_flush !== 1'b1 || bus.cur_epoch !== 1'b1) begin errors++;
            $display("FAIL areset_pre: got flush=%0h epoch=%0h want 1/1",
                bus.wb_flush, bus.cur_epoch); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if ({bus.wb_flush, bus.rf_we, bus.csr_we, bus.cur_epoch} !== 4'b0000) begin
            errors++; $display("FAIL areset_flags: got %b want 0000",
                {bus.wb_flush, bus.rf_we, bus.csr_we, bus.cur_epoch}); end
        checks++; if (bus.csr_in_bus !== '0 || bus.flush_target !== '0) begin errors++;
            $display("FAIL areset_bus: got %0h/%0h want 0/0", bus.csr_in_bus, bus.flush_target);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int commits = 0;
        for (int n = 0; n < 400; n++) begin
            present(($urandom_range(0, 4) == 0) ? ~m_epoch : m_epoch, $urandom,
                    ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
                    $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
                    5'($urandom), $urandom);
            bus.mem_to_wb_valid = ($urandom_range(0, 3) != 0);
            bus.ex_entry   = $urandom;
            bus.ertn_entry = $urandom;
            tick();
            if (m_slot.valid) commits++;
            checks++; if (bus.wb_allowin !== 1'b1 || bus.wb_flush !== e_flush) begin errors++;
                $display("FAIL rnd_flush[%0d]: got allowin=%0h flush=%0h want 1/%0h",
                    n, bus.wb_allowin, bus.wb_flush, e_flush); end
            checks++; if (bus.csr_in_bus !== e_bus) begin errors++;
                $display("FAIL rnd_bus[%0d]: got %0h want %0h", n, bus.csr_in_bus, e_bus); end
            checks++; if (bus.cur_epoch !== m_epoch) begin errors++;
                $display("FAIL rnd_epoch[%0d]: got %0h want %0h", n, bus.cur_epoch, m_epoch); end
            checks++; if (bus.rf_we !== e_rf_we || bus.csr_we !== e_csr_we) begin errors++;
                $display("FAIL rnd_we[%0d]: got rf=%0h csr=%0h want %0h/%0h",
                    n, bus.rf_we, bus.csr_we, e_rf_we, e_csr_we); end
            if (e_flush) begin
                checks++; if (bus.flush_target !== e_target) begin errors++;
                    $display("FAIL rnd_target[%0d]: got %0h want %0h",
                        n, bus.flush_target, e_target); end
            end
            if (m_slot.valid) begin
                checks++;
                if ({bus.rf_waddr, bus.rf_wdata, bus.csr_num, bus.csr_wmask, bus.csr_wvalue} !==
                    {m_slot.waddr, m_slot.wdata, m_slot.csr_num, m_slot.wmask, m_slot.wvalue})
                begin errors++; $display("FAIL rnd_payload[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h",
                    n, bus.rf_waddr, bus.rf_wdata, bus.csr_num,
                    m_slot.waddr, m_slot.wdata, m_slot.csr_num); end
            end
        end
        checks++; if (commits < 50) begin errors++;
            $display("FAIL rnd_activity: got %0d commits want >= 50", commits); end
        idle();
    endtask

    initial begin
        test_reset();
        test_normal_commit();
        test_syscall();
        test_priority();
        test_ertn();
        test_stale_epoch();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
